// File: rtl/fx2_bridge_pkg.sv
// Shared types and helpers for the FX2 16-bit slave-FIFO bridges.
// FX2_BYTE_SWAP_EN selects low-byte-first beats on the FX2 bus.
package fx2_bridge_pkg;

  localparam int BEATS    = 4;
  localparam int W_WIDE   = 64;
  localparam int W_NARROW = 16;
  localparam logic [1:0] LAST_CNT = 2'(BEATS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  function automatic logic [W_NARROW-1:0] beat(input logic [W_NARROW-1:0] x);
`ifdef FX2_BYTE_SWAP_EN
    return {x[7:0], x[15:8]};
`else
    return x;
`endif
  endfunction

endpackage

// File: rtl/b64_1to4_bridge.sv
// Serialises 64-bit words into four 16-bit FX2 write beats, MS beat first.
// Beat byte order follows FX2_BYTE_SWAP_EN (see fx2_bridge_pkg::beat).
module b64_1to4_bridge
  import fx2_bridge_pkg::*;
#(
  parameter logic [15:0] IDLE_VAL = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [63:0] d_i,
  input  logic        d_i_valid,
  output logic        d_i_ready,
  output logic [15:0] d_o,
  output logic        d_o_en,
  input  logic        d_o_ready,
  output logic        busy
);

  state_t              r_state;
  logic [W_WIDE-1:0]   r_sh;
  logic [W_WIDE-1:0]   r_hold;
  logic                r_hold_v;
  logic [1:0]          r_cnt;
  logic [W_NARROW-1:0] r_d_o;
  logic                r_d_o_en;

  state_t              w_state_next;
  logic [W_WIDE-1:0]   w_sh_next;
  logic [W_WIDE-1:0]   w_hold_next;
  logic                w_hold_v_next;
  logic [1:0]          w_cnt_next;
  logic [W_NARROW-1:0] w_d_o_next;
  logic                w_d_o_en_next;
  logic                w_accept;

  assign w_accept  = d_i_valid & ~r_hold_v;
  assign d_i_ready = ~r_hold_v;
  assign d_o       = r_d_o;
  assign d_o_en    = r_d_o_en;
  assign busy      = (r_state == SEND) | r_hold_v;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sh     <= '0;
      r_hold   <= '0;
      r_hold_v <= 1'b0;
      r_cnt    <= '0;
      r_d_o    <= IDLE_VAL;
      r_d_o_en <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_sh     <= w_sh_next;
      r_hold   <= w_hold_next;
      r_hold_v <= w_hold_v_next;
      r_cnt    <= w_cnt_next;
      r_d_o    <= w_d_o_next;
      r_d_o_en <= w_d_o_en_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_sh_next     = r_sh;
    w_hold_next   = r_hold;
    w_hold_v_next = r_hold_v;
    w_cnt_next    = r_cnt;
    w_d_o_next    = r_d_o;
    w_d_o_en_next = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_sh_next    = d_i;
          w_cnt_next   = '0;
          w_state_next = SEND;
        end
      end
      SEND: begin
        if (d_o_ready) begin
          w_d_o_next    = beat(r_sh[W_WIDE-1 -: W_NARROW]);
          w_d_o_en_next = 1'b1;
          w_sh_next     = r_sh << W_NARROW;
          w_cnt_next    = r_cnt + 2'd1;
          // Last beat: refill from hold first, then straight from the source.
          if (r_cnt == LAST_CNT) begin
            if (r_hold_v) begin
              w_sh_next     = r_hold;
              w_hold_v_next = 1'b0;
            end else if (w_accept) begin
              w_sh_next = d_i;
            end else begin
              w_state_next = IDLE;
            end
          end else if (w_accept) begin
            w_hold_next   = d_i;
            w_hold_v_next = 1'b1;
          end
        end else if (w_accept) begin
          w_hold_next   = d_i;
          w_hold_v_next = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_b64_1to4_bridge.sv
// Directed bench for b64_1to4_bridge with a beat scoreboard.
// Expected beat order follows FX2_BYTE_SWAP_EN the same way as the build.
module tb_b64_1to4_bridge;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic [63:0] d_i;
  logic        d_i_valid;
  logic        d_i_ready;
  logic [15:0] d_o;
  logic        d_o_en;
  logic        d_o_ready;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;
  int run_len  = 0;
  int max_run  = 0;
  int n_beats  = 0;
  logic [15:0] sb[$];

  b64_1to4_bridge #(.IDLE_VAL(16'h0000)) dut (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .d_i       (d_i),
    .d_i_valid (d_i_valid),
    .d_i_ready (d_i_ready),
    .d_o       (d_o),
    .d_o_en    (d_o_en),
    .d_o_ready (d_o_ready),
    .busy      (busy)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [15:0] exp_beat(input logic [15:0] x);
`ifdef FX2_BYTE_SWAP_EN
    return {x[7:0], x[15:8]};
`else
    return x;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  // Holds d_i/d_i_valid until an edge accepts the word; valid stays high afterwards.
  task automatic push_word(input logic [63:0] w);
    logic rdy;
    bit   done;
    done      = 1'b0;
    d_i       = w;
    d_i_valid = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      rdy = d_i_ready;
      @(posedge clk_i);
      if (rdy) begin
        for (int b = 0; b < 4; b++) sb.push_back(exp_beat(w[63-16*b -: 16]));
        done = 1'b1;
      end
      tick();
    end
    if (!done) check("accept_timeout", 64'(done), 64'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sb.size() != 0; t++) tick();
    check("drain_left", 64'(sb.size()), 64'd0);
    tick();
    check("idle_en", 64'(d_o_en), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  always @(negedge clk_i) begin
    if (d_o_en === 1'b1) begin
      run_len++;
      n_beats++;
      if (run_len > max_run) max_run = run_len;
      n_assert++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_beat: observed %0h expected none", d_o);
      end
      if (sb.size() != 0) begin
        $display("beat d_o=%04h", d_o);
        check("beat", 64'(d_o), 64'(sb.pop_front()));
      end
    end else begin
      run_len = 0;
    end
  end

  initial begin
    logic [15:0] b1;
    rst_n     = 1'b0;
    d_i       = '0;
    d_i_valid = 1'b0;
    d_o_ready = 1'b1;
    repeat (2) tick();
    check("rst_d_o", 64'(d_o), 64'h0000);
    check("rst_en", 64'(d_o_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    tick();
    check("rst_ready", 64'(d_i_ready), 64'd1);
    tick();
    check("idle_no_beat", 64'(d_o_en), 64'd0);

    // Single word
    push_word(64'h0011_2233_4455_6677);
    d_i_valid = 1'b0;
    check("lat_no_beat_yet", 64'(d_o_en), 64'd0);
    tick();
`ifdef FX2_BYTE_SWAP_EN
    check("first_beat_const", 64'(d_o), 64'h1100);
`else
    check("first_beat_const", 64'(d_o), 64'h0011);
`endif
    check("first_beat_en", 64'(d_o_en), 64'd1);
    drain();

    // Back-to-back, three words
    max_run = 0;
    push_word(64'h0102_0304_0506_0708);
    push_word(64'h1112_1314_1516_1718);
    check("b2b_ready_low", 64'(d_i_ready), 64'd0);
    push_word(64'h2122_2324_2526_2728);
    d_i_valid = 1'b0;
    drain();
    check("b2b_run", 64'(max_run), 64'd12);

    // Backpressure after beat 1
    push_word(64'hA1A2_B1B2_C1C2_D1D2);
    d_i_valid = 1'b0;
    b1 = exp_beat(16'hA1A2);
    tick();
    check("bp_beat1_en", 64'(d_o_en), 64'd1);
    d_o_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      check("bp_stall_en", 64'(d_o_en), 64'd0);
      check("bp_stall_d_o", 64'(d_o), 64'(b1));
    end
    d_o_ready = 1'b1;
    drain();

    // Hold full at the last-beat edge
    push_word(64'h3333_4444_5555_6666);
    push_word(64'h7777_8888_9999_0000);
    d_i = 64'hDEAD_BEEF_CAFE_F00D;
    tick();
    tick();
    check("hold_lastbeat_ready", 64'(d_i_ready), 64'd0);
    tick();
    check("hold_drained_ready", 64'(d_i_ready), 64'd1);
    push_word(64'hDEAD_BEEF_CAFE_F00D);
    d_i_valid = 1'b0;
    drain();

    // Reset after beat 2 with hold full
    push_word(64'h1234_5678_9ABC_DEF0);
    push_word(64'h0FED_CBA9_8765_4321);
    d_i_valid = 1'b0;
    tick();
    check("pre_rst_hold", 64'(d_i_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_en", 64'(d_o_en), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_d_o", 64'(d_o), 64'h0000);
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    n_beats = 0;
    push_word(64'hAAAA_BBBB_CCCC_DDDD);
    d_i_valid = 1'b0;
    drain();
    repeat (4) tick();
    check("post_rst_beats", 64'(n_beats), 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/b64_1to4_bridge.md
Name: b64_1to4_bridge

Overview:
- Transmit-direction companion of the 16-to-64 receive bridge: serialises one 64-bit word into four 16-bit beats on clk_i for the FX2 16-bit slave-FIFO write path.
- Sits between the 64-bit DES datapath output and the FX2 write interface.
- Two-deep buffering (shift register plus one holding register) sustains one word every 4 clocks with no bubbles.
- Downstream backpressure (FX2 FIFO full) stalls serialisation beat-by-beat.

Parameters:
- IDLE_VAL, 16'h0000, value driven on d_o after reset; d_o is don't-care whenever d_o_en=0 after that.

Ports:
- clk_i  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- d_i  input  64  parallel word; bits [63:48] are sent first
- d_i_valid  input  1  d_i holds a word
- d_i_ready  output  1  bridge can accept; transfer occurs when d_i_valid & d_i_ready at a rising edge
- d_o  output  16  serial beat, registered
- d_o_en  output  1  d_o is a valid beat this cycle, registered
- d_o_ready  input  1  downstream can take a beat (FX2 not full)
- busy  output  1  word in shift or hold register, or beat pending

Behaviour:
- Interface fixed: reset rst_n, asynchronous, active-low; clock clk_i.
- Reset values:
  - d_o=IDLE_VAL, d_o_en=0, busy=0.
  - Shift reg sh=0, hold reg=0, hold_v=0, beat counter cnt=0, state=IDLE.
  - d_i_ready=1 once reset deasserts.
- d_i_ready is combinational: d_i_ready = !hold_v.
- State machine:
  - IDLE: sh empty. On acceptance, load d_i into sh, cnt=0, go to SEND.
  - SEND, edge with d_o_ready=1: d_o<=beat(sh[63:48]), d_o_en<=1, sh<<=16, cnt<=cnt+1 (2-bit, wraps 3 to 0).
  - SEND, edge with d_o_ready=0: d_o_en<=0, d_o, sh and cnt hold (stall).
  - Last beat (cnt==3 and d_o_ready=1), in priority order:
    1. hold_v=1: sh<=hold, hold_v<=0, stay SEND.
    2. Else, if accepting d_i this edge: sh<=d_i, stay SEND.
    3. Else: go to IDLE.
  - Acceptance in SEND when not on the last-beat edge: d_i goes to hold, hold_v<=1.
- Latency: word accepted at edge N gives first beat with d_o_en=1 in the cycle after edge N+1 (1-cycle load, then registered output). Four beats follow on consecutive d_o_ready cycles.
- Throughput: with d_o_ready held at 1 and the source always valid, d_o_en stays high continuously.
- Simultaneous events:
  - Last-beat edge with hold full: hold drains to sh; the same edge may not also accept (d_i_ready was 0).
  - Last-beat edge with d_o_ready=0: not a last beat; nothing moves.
- busy = (state==SEND) | hold_v.
- Reset mid-word: remaining beats are dropped, held word is discarded, d_o_en falls immediately (asynchronously). No partial word resumes after reset.
- IDLE with no input: d_o_en=0 every cycle.

Optional Feature:
- Macro: FX2_BYTE_SWAP_EN.
  - Defined: beat(x) = {x[7:0], x[15:8]}, so the FX2 sends the low byte first. This is the exact inverse of the receive bridge's swap.
  - Undefined: beat(x) = x, no swap.
- Macro only changes the wiring; timing is identical either way.

Decomposition:
- Shared package fx2_bridge_pkg:
  - BEATS=4, W_WIDE=64, W_NARROW=16.
  - State enum {IDLE, SEND}.
  - Byte-swap function, guarded by FX2_BYTE_SWAP_EN.
- Single module; no sub-module. The hold register is too small to justify a FIFO instance.

Test Plan:
- Single word, swap on: d_i=64'h0011_2233_4455_6677, d_o_ready=1 -> 4 consecutive d_o_en beats 16'h1100, 3322, 5544, 7766; then d_o_en=0 and busy=0.
- Back-to-back, source always valid, 3 words, d_o_ready=1 -> 12 contiguous d_o_en cycles; d_i_ready drops after the 2nd accept and rises after each hold drain.
- Backpressure: d_o_ready=0 for 3 cycles after beat 1 -> d_o_en=0 and d_o frozen during the stall, then beats 2-4 in order; no data lost.
- Hold full + last-beat edge with d_i_valid=1 -> third word not accepted that edge (d_i_ready=0); it is accepted on a later edge and emitted after the held word.
- Reset asserted after beat 2 with hold full -> d_o_en=0, busy=0, d_o=IDLE_VAL at once. After release, a new word 64'hAAAA_BBBB_CCCC_DDDD produces exactly its 4 beats.
- Swap off (macro undefined), word 64'h0011_2233_4455_6677 -> beats 16'h0011, 2233, 4455, 6677.
